// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for the in-order core.
//   Combines per-stage stall requests with a multi-cycle execute sequencer into a
//   thermometer stall vector. It also registers branch/exception redirects into a
//   one-cycle flush pulse with a new PC.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   stallreq_i           per-stage stall request (bit k from stage k)
//   mc_start_i           MC_STAGE starts a multi-cycle op of mc_cycles_i cycles
//   mc_cycles_i          op length N (sampled with mc_start_i)
//   flush_req_i          redirect request
//   flush_pc_i           redirect target (sampled with flush_req_i)
//   stall_o              stall vector, stall_o[k]=1 freezes stage k
//   flush_o, new_pc_o    registered flush pulse and redirect target
//   mc_busy_o            multi-cycle op is holding the pipeline
//   mc_done_o            pulse in the final cycle of a multi-cycle op
module pipe_ctrl #(
  parameter int unsigned STAGES   = 6,
  parameter int unsigned MC_STAGE = 3,
  parameter int unsigned MC_CNT_W = 6,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STAGES-1:0]   stallreq_i,
  input  logic                mc_start_i,
  input  logic [MC_CNT_W-1:0] mc_cycles_i,
  input  logic                flush_req_i,
  input  logic [ADDR_W-1:0]   flush_pc_i,
  output logic [STAGES-1:0]   stall_o,
  output logic                flush_o,
  output logic [ADDR_W-1:0]   new_pc_o,
  output logic                mc_busy_o,
  output logic                mc_done_o
);

  typedef enum logic [1:0] {StIdle, StMcRun, StFlush} state_e;

  state_e              state_q;
  logic [MC_CNT_W-1:0] cnt_q;
  logic                mc_hold;
  logic [STAGES-1:0]   req;
  logic                acc;

  // Hold/done are decoded from the current state so the stall response is
  // combinational. A same-cycle flush aborts the op, so it suppresses done.
  always_comb begin
    mc_hold   = 1'b0;
    mc_done_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mc_start_i && (mc_cycles_i != '0)) begin
          mc_hold   = 1'b1;
          mc_done_o = (mc_cycles_i == MC_CNT_W'(1)) && !flush_req_i;
        end
      end
      StMcRun: begin
        mc_hold   = 1'b1;
        mc_done_o = (cnt_q == '0) && !flush_req_i;
      end
      StFlush: begin
        mc_hold = 1'b0;
      end
      default: begin
        mc_hold = 1'b0;
      end
    endcase
    if (rst) begin
      mc_hold   = 1'b0;
      mc_done_o = 1'b0;
    end
  end

  assign mc_busy_o = mc_hold;

  // Stalling stage k must freeze every upstream stage too, so fill the
  // stall vector downward from the highest requesting stage.
  always_comb begin
    req = stallreq_i | (STAGES'(mc_hold) << MC_STAGE);
    acc = 1'b0;
    stall_o = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc        = acc | req[k];
      stall_o[k] = acc;
    end
    // A flush discards all stage contents, so it must never be held off.
    if (rst || (state_q == StFlush)) begin
      stall_o = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      flush_o  <= 1'b0;
      new_pc_o <= '0;
    end else if (flush_req_i) begin
      state_q  <= StFlush;
      cnt_q    <= '0;
      flush_o  <= 1'b1;
      new_pc_o <= flush_pc_i;
    end else begin
      unique case (state_q)
        StIdle: begin
          // N=1 finishes in the start cycle; N>=2 counts the remaining N-1 cycles.
          if (mc_start_i && (mc_cycles_i >= MC_CNT_W'(2))) begin
            cnt_q   <= mc_cycles_i - MC_CNT_W'(2);
            state_q <= StMcRun;
          end
        end
        StMcRun: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - MC_CNT_W'(1);
          end
        end
        StFlush: begin
          state_q <= StIdle;
          flush_o <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          flush_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the stimulus process pushes one expected
// output set per driven cycle, and a negedge monitor pops and compares.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  stallreq_i;
  logic        mc_start_i;
  logic [5:0]  mc_cycles_i;
  logic        flush_req_i;
  logic [31:0] flush_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        mc_busy_o;
  logic        mc_done_o;

  pipe_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .stallreq_i (stallreq_i),
    .mc_start_i (mc_start_i),
    .mc_cycles_i(mc_cycles_i),
    .flush_req_i(flush_req_i),
    .flush_pc_i (flush_pc_i),
    .stall_o    (stall_o),
    .flush_o    (flush_o),
    .new_pc_o   (new_pc_o),
    .mc_busy_o  (mc_busy_o),
    .mc_done_o  (mc_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        busy;
    logic        done;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Monitor: compares mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_total++;
      if ({stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o} ===
          {e.stall, e.flush, e.pc, e.busy, e.done}) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got stall=%b flush=%b pc=%h busy=%b done=%b, want stall=%b flush=%b pc=%h busy=%b done=%b",
                 e.name, stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o,
                 e.stall, e.flush, e.pc, e.busy, e.done);
      end
    end
  end

  task automatic push(input logic [5:0] es, input logic ef, input logic [31:0] ep,
                      input logic eb, input logic ed, input string nm);
    exp_t e;
    e.stall = es; e.flush = ef; e.pc = ep; e.busy = eb; e.done = ed; e.name = nm;
    q.push_back(e);
  endtask

  task automatic drive(input logic [5:0] sr, input logic st, input logic [5:0] n,
                       input logic fr, input logic [31:0] fpc);
    stallreq_i  = sr;
    mc_start_i  = st;
    mc_cycles_i = n;
    flush_req_i = fr;
    flush_pc_i  = fpc;
  endtask

  // One clock cycle: drive inputs, queue the expected outputs, advance.
  task automatic cyc(input logic [5:0] sr, input logic st, input logic [5:0] n,
                     input logic fr, input logic [31:0] fpc,
                     input logic [5:0] es, input logic ef, input logic [31:0] ep,
                     input logic eb, input logic ed, input string nm);
    drive(sr, st, n, fr, fpc);
    push(es, ef, ep, eb, ed, nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(6'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    // Reset: outputs stay 0 whatever the inputs do.
    cyc(6'b111111, 1'b1, 6'd3, 1'b0, 32'h0, 6'b0, 0, 32'h0, 0, 0, "reset_forced_zero");
    rst = 1'b0;

    // Stall rule.
    cyc(6'b000100, 0, 6'd0, 0, 32'h0, 6'b000111, 0, 32'h0, 0, 0, "stall_bit2");
    cyc(6'b010100, 0, 6'd0, 0, 32'h0, 6'b011111, 0, 32'h0, 0, 0, "stall_bit4");
    cyc(6'b000000, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, "stall_none");

    // N=4 op; the second start is ignored and stall requests merge in.
    cyc(6'b000000, 1, 6'd4, 0, 32'h0, 6'b001111, 0, 32'h0, 1, 0, "mc4_c0");
    cyc(6'b100000, 1, 6'd4, 0, 32'h0, 6'b111111, 0, 32'h0, 1, 0, "mc4_c1_restart");
    cyc(6'b000001, 0, 6'd0, 0, 32'h0, 6'b001111, 0, 32'h0, 1, 0, "mc4_c2");
    cyc(6'b000000, 0, 6'd0, 0, 32'h0, 6'b001111, 0, 32'h0, 1, 1, "mc4_c3_done");
    cyc(6'b000000, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, "mc4_after");

    // N=1 and N=0.
    cyc(6'b000000, 1, 6'd1, 0, 32'h0, 6'b001111, 0, 32'h0, 1, 1, "mc1_done");
    cyc(6'b000000, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, "mc1_after");
    cyc(6'b000000, 1, 6'd0, 0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, "mc0_ignored");
    cyc(6'b000000, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, "mc0_after");

    // N=6 op aborted by a flush in its third cycle.
    cyc(6'b000000, 1, 6'd6, 0, 32'h0,   6'b001111, 0, 32'h0,   1, 0, "abort_c0");
    cyc(6'b000000, 0, 6'd0, 0, 32'h0,   6'b001111, 0, 32'h0,   1, 0, "abort_c1");
    cyc(6'b000000, 0, 6'd0, 1, 32'h100, 6'b001111, 0, 32'h0,   1, 0, "abort_flushreq");
    cyc(6'b000011, 1, 6'd3, 0, 32'h0,   6'b000000, 1, 32'h100, 0, 0, "abort_flush");
    cyc(6'b000000, 0, 6'd0, 0, 32'h0,   6'b000000, 0, 32'h100, 0, 0, "abort_pc_hold");
    cyc(6'b000000, 0, 6'd0, 0, 32'h0,   6'b000000, 0, 32'h100, 0, 0, "abort_no_done");

    // Back-to-back flushes; flush overrides a full stall request.
    cyc(6'b000000, 0, 6'd0, 1, 32'h200, 6'b000000, 0, 32'h100, 0, 0, "flush2_req0");
    cyc(6'b111111, 0, 6'd0, 1, 32'h300, 6'b000000, 1, 32'h200, 0, 0, "flush2_first");
    cyc(6'b000000, 0, 6'd0, 0, 32'h0,   6'b000000, 1, 32'h300, 0, 0, "flush2_second");
    cyc(6'b000000, 0, 6'd0, 0, 32'h0,   6'b000000, 0, 32'h300, 0, 0, "flush2_end");

    // Async reset with the counter at 3 (N=5, one cycle in).
    cyc(6'b000000, 1, 6'd5, 0, 32'h0, 6'b001111, 0, 32'h300, 1, 0, "rst_mc_c0");
    drive(6'b000000, 0, 6'd0, 0, 32'h0);
    #2;
    rst = 1'b1;
    push(6'b0, 0, 32'h0, 0, 0, "rst_midcycle");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(6'b000000, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, "rst_released");
    cyc(6'b000000, 1, 6'd2, 0, 32'h0, 6'b001111, 0, 32'h0, 1, 0, "mc2_c0");
    cyc(6'b000000, 0, 6'd0, 0, 32'h0, 6'b001111, 0, 32'h0, 1, 1, "mc2_c1_done");
    cyc(6'b000000, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, "mc2_after");

    // Let the monitor drain within a bounded number of cycles.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #1;
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
